spgd_step_ctrl: RTL and testbench

Sequencer for the SPGD loop. It drives one DAC actuator through repeated two-sided perturbation steps and triggers the ADC capture block for each side. It takes the 16Q48 metric from each capture and updates the DAC base code from the metric difference. It sits between the ADC capture path (enable/DONE/16Q48 result) and the DACB code output of the ADC/DAC loop top.

---
 rtl/spgd_step_ctrl.sv | 163 ++++++++++++++++
 tb/tb_spgd_step_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spgd_step_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// Module  : spgd_step_ctrl
// Purpose : SPGD two-sided perturbation sequencer driving one DAC base code
// Revision: 1.0
// ------------------------------------------------------------------------
module spgd_step_ctrl #(
  parameter int FLOAT_WIDTH    = 64,
  parameter int DAC_WIDTH      = 14,
  parameter int SETTLE_WIDTH   = 16,
  parameter int BASE_INIT      = 8192,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    ADC_CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [SETTLE_WIDTH-1:0] SETTLE_CYCLES,
  input  logic [DAC_WIDTH-1:0]    PERTURB,
  input  logic [5:0]              DELTA_SHIFT,
  input  logic                    ADC_DONE,
  input  logic [FLOAT_WIDTH-1:0]  ADC_METRIC,
  output logic                    ADC_ENABLE,
  output logic [DAC_WIDTH-1:0]    DAC_CODE_OUT,
  output logic                    BUSY,
  output logic                    STEP_DONE,
  output logic [31:0]             STEP_COUNT,
  output logic                    ERR
);

  localparam int WW = FLOAT_WIDTH + 2;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_APPLY_P  = 3'd1;
  localparam logic [2:0] S_SETTLE_P = 3'd2;
  localparam logic [2:0] S_MEAS_P   = 3'd3;
  localparam logic [2:0] S_APPLY_M  = 3'd4;
  localparam logic [2:0] S_SETTLE_M = 3'd5;
  localparam logic [2:0] S_MEAS_M   = 3'd6;
  localparam logic [2:0] S_UPDATE   = 3'd7;

  localparam logic [DAC_WIDTH-1:0] BASE_RST = DAC_WIDTH'(BASE_INIT);
  localparam logic signed [WW-1:0] CODE_MAX = {{(WW-DAC_WIDTH){1'b0}}, {DAC_WIDTH{1'b1}}};
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]                    state;
  logic [DAC_WIDTH-1:0]          base;
  logic [DAC_WIDTH-1:0]          dac_code;
  logic [31:0]                   step_count;
  logic                          err;
  logic signed [FLOAT_WIDTH-1:0] j_p;
  logic signed [FLOAT_WIDTH-1:0] j_m;
  logic                          armed;
  logic [SETTLE_WIDTH-1:0]       settle_cnt;
  logic [TW-1:0]                 tmo_cnt;

  logic signed [WW-1:0]          base_w;
  logic signed [WW-1:0]          perturb_w;
  logic signed [FLOAT_WIDTH:0]   diff;
  logic signed [FLOAT_WIDTH:0]   delta;
  logic [DAC_WIDTH-1:0]          code_plus;
  logic [DAC_WIDTH-1:0]          code_minus;
  logic [DAC_WIDTH-1:0]          new_base;
  logic                          capture;

  // Operands are widened to FLOAT_WIDTH+2 so no sum or difference can wrap before clamping.
  function automatic logic [DAC_WIDTH-1:0] sat(input logic signed [WW-1:0] v);
    logic [DAC_WIDTH-1:0] r;
    if (v[WW-1])
      r = '0;
    else if (v > CODE_MAX)
      r = {DAC_WIDTH{1'b1}};
    else
      r = v[DAC_WIDTH-1:0];
    return r;
  endfunction

  always_comb begin
    base_w     = {{(WW-DAC_WIDTH){1'b0}}, base};
    perturb_w  = {{(WW-DAC_WIDTH){1'b0}}, PERTURB};
    diff       = {j_p[FLOAT_WIDTH-1], j_p} - {j_m[FLOAT_WIDTH-1], j_m};
    delta      = diff >>> DELTA_SHIFT;
    code_plus  = sat(base_w + perturb_w);
    code_minus = sat(base_w - perturb_w);
    new_base   = sat(base_w + {delta[FLOAT_WIDTH], delta});
    capture    = armed && ADC_DONE;
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      base       <= BASE_RST;
      dac_code   <= BASE_RST;
      step_count <= '0;
      err        <= 1'b0;
      j_p        <= '0;
      j_m        <= '0;
      armed      <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          dac_code <= base;
          if (START)
            state <= S_APPLY_P;
        end
        S_APPLY_P, S_APPLY_M: begin
          dac_code   <= (state == S_APPLY_P) ? code_plus : code_minus;
          settle_cnt <= SETTLE_CYCLES;
          state      <= (state == S_APPLY_P) ? S_SETTLE_P : S_SETTLE_M;
        end
        S_SETTLE_P, S_SETTLE_M: begin
          if (settle_cnt == '0) begin
            tmo_cnt <= '0;
            armed   <= 1'b0;
            state   <= (state == S_SETTLE_P) ? S_MEAS_P : S_MEAS_M;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
          end
        end
        S_MEAS_P, S_MEAS_M: begin
          // A DONE level is only trusted after it has been seen low in this measurement.
          if (capture) begin
            armed <= 1'b0;
            if (state == S_MEAS_P) begin
              j_p   <= ADC_METRIC;
              state <= S_APPLY_M;
            end else begin
              j_m   <= ADC_METRIC;
              state <= S_UPDATE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err      <= 1'b1;
            armed    <= 1'b0;
            dac_code <= base;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (!ADC_DONE)
              armed <= 1'b1;
          end
        end
        S_UPDATE: begin
          base       <= new_base;
          dac_code   <= new_base;
          step_count <= step_count + 32'd1;
          state      <= START ? S_APPLY_P : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ADC_ENABLE   = (state == S_MEAS_P) || (state == S_MEAS_M);
  assign BUSY         = (state != S_IDLE);
  assign STEP_DONE    = (state == S_UPDATE);
  assign DAC_CODE_OUT = dac_code;
  assign STEP_COUNT   = step_count;
  assign ERR          = err;

endmodule
`default_nettype wire

// File: tb/tb_spgd_step_ctrl.sv
`default_nettype none
// Directed bench for spgd_step_ctrl: step arithmetic, saturation, stale DONE,
// timeout and reset/START behaviour, with hand-computed expected codes.
module tb_spgd_step_ctrl;

  localparam logic [63:0] FIVE = 64'h0005_0000_0000_0000;
  localparam logic [63:0] TWO  = 64'h0002_0000_0000_0000;
  localparam logic [63:0] NINE = 64'h0009_0000_0000_0000;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] settle = 16'd3;
  logic [13:0] perturb = 14'd100;
  logic [5:0]  shift = 6'd44;
  logic        adc_done = 1'b0;
  logic [63:0] adc_metric = '0;
  logic        adc_enable;
  logic [13:0] dac_code;
  logic        busy;
  logic        step_done;
  logic [31:0] step_count;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;
  int cyc = 0;

  spgd_step_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .ADC_CLK(clk), .RST(rst), .START(start), .SETTLE_CYCLES(settle),
    .PERTURB(perturb), .DELTA_SHIFT(shift), .ADC_DONE(adc_done),
    .ADC_METRIC(adc_metric), .ADC_ENABLE(adc_enable), .DAC_CODE_OUT(dac_code),
    .BUSY(busy), .STEP_DONE(step_done), .STEP_COUNT(step_count), .ERR(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (step_done) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 1'b0; adc_done = 1'b0; adc_metric = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_busy(output int t);
    int n = 0;
    while (!busy && n < 50) begin tick(); n++; end
    check("busy_rise", {63'd0, busy}, 64'd1);
    t = cyc;
  endtask

  // Acts as the ADC: raises DONE d cycles after ENABLE is seen, drops it when ENABLE falls.
  task automatic serve(input logic [63:0] m, input int d, output logic [13:0] dac_at_en);
    int n = 0;
    while (!adc_enable && n < 200) begin tick(); n++; end
    check("enable_rise", {63'd0, adc_enable}, 64'd1);
    dac_at_en = dac_code;
    repeat (d) tick();
    adc_done = 1'b1; adc_metric = m;
    n = 0;
    while (adc_enable && n < 200) begin tick(); n++; end
    check("enable_fall", {63'd0, adc_enable}, 64'd0);
    adc_done = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    while (!step_done && n < 200) begin tick(); n++; end
    check("step_done_seen", {63'd0, step_done}, 64'd1);
    t = cyc;
  endtask

  task automatic do_step(input logic [63:0] jp, input logic [63:0] jm,
                         output logic [13:0] dp, output logic [13:0] dm, output logic [13:0] nb);
    int t;
    serve(jp, 2, dp);
    serve(jm, 2, dm);
    wait_done(t);
    tick();
    nb = dac_code;
  endtask

  initial begin
    int t0, t1, n, p0;
    logic [13:0] dp, dm, nb;
    logic en_ok;

    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, n, p0;
    logic [13:0] dp, dm, nb;
    logic en_ok;

    // Reset values, then one step with START dropped during SETTLE_P
    do_reset();
    check("rst_dac", dac_code, 8192);
    check("rst_busy", busy, 0);
    check("rst_enable", adc_enable, 0);
    check("rst_step_done", step_done, 0);
    check("rst_count", step_count, 0);
    check("rst_err", err, 0);
    p0 = pulses;
    start = 1'b1;
    wait_busy(t0);
    tick();
    start = 1'b0;
    serve(FIVE, 2, dp);
    serve(TWO, 2, dm);
    wait_done(t1);
    check("t1_latency", t1 - t0 + 1, 17);
    tick();
    nb = dac_code;
    check("t1_dac_p", dp, 8292);
    check("t1_dac_m", dm, 8092);
    check("t1_new_base", nb, 8240);
    repeat (3) tick();
    check("t1_pulses", pulses - p0, 1);
    check("t1_count", step_count, 1);
    check("t1_busy_after", busy, 0);
    check("t1_dac_idle", dac_code, 8240);

    // Swapped metrics move the base down
    do_reset();
    start = 1'b1;
    wait_busy(t0);
    start = 1'b0;
    do_step(TWO, FIVE, dp, dm, nb);
    check("t2_dac_p", dp, 8292);
    check("t2_dac_m", dm, 8092);
    check("t2_new_base", nb, 8144);

    // Saturation at both ends of the code range, with a 65-bit difference
    do_reset();
    start = 1'b1;
    do_step(64'(8188) << 44, 64'd0, dp, dm, nb);
    check("t3_base_16380", nb, 16380);
    do_step(MAXP, MINN, dp, dm, nb);
    check("t3_dac_p_clamp", dp, 16383);
    check("t3_dac_m", dm, 16280);
    check("t3_upd_clamp_hi", nb, 16383);
    do_step(MINN, MAXP, dp, dm, nb);
    check("t3_upd_clamp_lo", nb, 0);
    start = 1'b0;
    do_step(MINN, MAXP, dp, dm, nb);
    check("t3_low_dac_p", dp, 100);
    check("t3_low_dac_m_clamp", dm, 0);
    check("t3_low_upd_clamp", nb, 0);
    check("t3_count", step_count, 4);

    // Stale DONE held high into MEAS_P must not be captured
    do_reset();
    adc_done = 1'b1; adc_metric = NINE;
    start = 1'b1;
    wait_busy(t0);
    start = 1'b0;
    n = 0;
    while (!adc_enable && n < 200) begin tick(); n++; end
    check("t4_enable_rise", adc_enable, 1);
    en_ok = 1'b1;
    repeat (5) begin tick(); if (!adc_enable) en_ok = 1'b0; end
    check("t4_enable_held", en_ok, 1);
    adc_done = 1'b0;
    tick();
    adc_done = 1'b1; adc_metric = FIVE;
    n = 0;
    while (adc_enable && n < 200) begin tick(); n++; end
    adc_done = 1'b0;
    serve(TWO, 2, dm);
    wait_done(t1);
    tick();
    check("t4_new_base", dac_code, 8240);

    // Timeout after 16 MEAS cycles with no DONE
    do_reset();
    start = 1'b1;
    n = 0;
    while (!adc_enable && n < 200) begin tick(); n++; end
    start = 1'b0;
    check("t5_err_before", err, 0);
    n = 0;
    while (adc_enable && n < 100) begin n++; tick(); end
    check("t5_meas_cycles", n, 16);
    check("t5_err", err, 1);
    check("t5_busy", busy, 0);
    check("t5_dac", dac_code, 8192);
    check("t5_count", step_count, 0);

    // ERR does not block a restart; it stays set
    start = 1'b1;
    do_step(FIVE, TWO, dp, dm, nb);
    check("t5_restart_base", nb, 8240);
    check("t5_err_sticky", err, 1);
    check("t5_restart_count", step_count, 1);

    // Asynchronous reset in SETTLE_M of the following step
    serve(FIVE, 2, dp);
    tick();
    check("t6_busy_settle_m", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dac", dac_code, 8192);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", step_count, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_enable", adc_enable, 0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("t6_idle_after_rst", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
